fc_layer_sequencer: RTL and testbench

Controller for the fully-connected output layer: sequences one shared signed multiply-accumulate datapath over N_IN activations and N_OUT neurons, generates read addresses for the activation buffer, weight ROM and bias ROM, and emits each neuron's saturated 16-bit result as it completes. After the last neuron it reports the arg-max class index. It sits between the upstream feature buffer and the 10 signed 16-bit fully-connected outputs consumed by the classifier.

---
 rtl/fc_layer_sequencer_if.sv | 34 +++
 rtl/fc_layer_sequencer.sv | 142 ++++++++++++++
 tb/tb_fc_layer_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fc_layer_sequencer_if.sv
// Handshake and memory-port bundle between the FC layer sequencer and its
// activation buffer, weight/bias ROMs and result consumer.
interface fc_layer_sequencer_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int DW    = 16
);
  localparam int XW  = $clog2(N_IN);
  localparam int WAW = $clog2(N_IN * N_OUT);

  logic                  start;
  logic                  busy;
  logic [XW-1:0]         x_addr;
  logic [WAW-1:0]        w_addr;
  logic [3:0]            b_addr;
  logic signed [DW-1:0]  x_data;
  logic signed [DW-1:0]  w_data;
  logic signed [DW-1:0]  b_data;
  logic                  out_valid;
  logic [3:0]            out_idx;
  logic signed [DW-1:0]  out_data;
  logic                  done;
  logic [3:0]            class_idx;

  modport master (
    output start, x_data, w_data, b_data,
    input  busy, x_addr, w_addr, b_addr, out_valid, out_idx, out_data, done, class_idx
  );

  modport slave (
    input  start, x_data, w_data, b_data,
    output busy, x_addr, w_addr, b_addr, out_valid, out_idx, out_data, done, class_idx
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Sequences one signed MAC over N_IN activations for each of N_OUT neurons,
// emits saturated Q8.8 results and the arg-max class at the end of a pass.
module fc_layer_sequencer #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 10,
  parameter int DW    = 16,
  parameter int ACC_W = 40
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_layer_sequencer_if.slave   bus
);
  localparam int XW  = $clog2(N_IN);
  localparam int WAW = $clog2(N_IN * N_OUT);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, CLR, MAC, OUT, DONE} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             n;
  logic [XW-1:0]          k;
  logic signed [ACC_W-1:0] acc;
  logic signed [DW-1:0]   best;
  logic [3:0]             best_idx;

  logic [XW-1:0]          x_addr_r;
  logic [WAW-1:0]         w_addr_r;
  logic [3:0]             b_addr_r;
  logic                   out_valid_r, done_r;
  logic [3:0]             out_idx_r, class_idx_r;
  logic signed [DW-1:0]   out_data_r;

  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_sum, bias_ext, sum_b, res_full;
  logic signed [DW-1:0]    res;
  logic                    last_k, last_n;

  assign prod     = bus.x_data * bus.w_data;
  assign acc_sum  = acc + ACC_W'(prod);
  assign bias_ext = ACC_W'(bus.b_data);
  assign sum_b    = acc_sum + (bias_ext <<< 8);
  assign res_full = sum_b >>> 8;
  assign last_k   = (k == XW'(N_IN - 1));
  assign last_n   = (n == 4'(N_OUT - 1));

  always_comb begin
    res = res_full[DW-1:0];
    if (res_full > SAT_MAX)      res = SAT_MAX[DW-1:0];
    else if (res_full < SAT_MIN) res = SAT_MIN[DW-1:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = CLR;
      CLR:  state_nxt = MAC;
      MAC:  if (last_k) state_nxt = OUT;
      OUT:  state_nxt = last_n ? DONE : CLR;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The result is registered on the edge that closes the last MAC so that
  // out_valid is already high during the OUT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      n           <= '0;
      k           <= '0;
      acc         <= '0;
      best        <= '0;
      best_idx    <= '0;
      x_addr_r    <= '0;
      w_addr_r    <= '0;
      b_addr_r    <= '0;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      out_idx_r   <= '0;
      out_data_r  <= '0;
      class_idx_r <= '0;
    end else begin
      state       <= state_nxt;
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
      case (state)
        IDLE: if (bus.start) begin
          n        <= '0;
          x_addr_r <= '0;
          w_addr_r <= '0;
          b_addr_r <= '0;
        end
        CLR: begin
          acc      <= '0;
          k        <= '0;
          x_addr_r <= XW'(1);
          w_addr_r <= w_addr_r + WAW'(1);
        end
        MAC: begin
          acc <= acc_sum;
          if (!last_k) k <= k + XW'(1);
          if (x_addr_r != XW'(N_IN - 1)) begin
            x_addr_r <= x_addr_r + XW'(1);
            w_addr_r <= w_addr_r + WAW'(1);
          end
          if (last_k) begin
            out_data_r  <= res;
            out_idx_r   <= n;
            out_valid_r <= 1'b1;
            if (n == '0 || res > best) begin
              best     <= res;
              best_idx <= n;
            end
          end
        end
        OUT: begin
          if (!last_n) begin
            n        <= n + 4'd1;
            x_addr_r <= '0;
            w_addr_r <= w_addr_r + WAW'(1);
            b_addr_r <= n + 4'd1;
          end else begin
            done_r      <= 1'b1;
            class_idx_r <= best_idx;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.x_addr    = x_addr_r;
  assign bus.w_addr    = w_addr_r;
  assign bus.b_addr    = b_addr_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_data  = out_data_r;
  assign bus.done      = done_r;
  assign bus.class_idx = class_idx_r;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer: a plain-arithmetic layer model
// predicts every result, its cycle and the arg-max; a monitor checks them.
module tb_fc_layer_sequencer;
  localparam int N_IN     = 16;
  localparam int N_OUT    = 10;
  localparam int DW       = 16;
  localparam int PASS_CYC = N_OUT * (N_IN + 2);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_layer_sequencer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW)) bus ();

  fc_layer_sequencer #(.N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .ACC_W(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DW-1:0] xmem [N_IN];
  logic signed [DW-1:0] wmem [N_IN*N_OUT];
  logic signed [DW-1:0] bmem [N_OUT];

  always @(posedge clk) begin
    bus.x_data <= xmem[bus.x_addr];
    bus.w_data <= wmem[bus.w_addr];
    bus.b_data <= bmem[bus.b_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_done;
    int unsigned idx;
    logic [15:0] data;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          passed = 0;
  int unsigned last_class = 0;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act == expv) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic push_pass(input int unsigned e0);
    longint      s, r, best;
    int unsigned bi;
    exp_t        e;
    best = 0;
    bi   = 0;
    for (int n = 0; n < N_OUT; n++) begin
      s = 0;
      for (int i = 0; i < N_IN; i++)
        s += longint'(xmem[i]) * longint'(wmem[n*N_IN + i]);
      s += longint'(bmem[n]) * 256;
      r = s >>> 8;
      if (r > 32767) r = 32767;
      else if (r < -32768) r = -32768;
      if (n == 0 || r > best) begin
        best = r;
        bi   = n;
      end
      e.is_done = 1'b0;
      e.idx     = n;
      e.data    = 16'(r);
      e.at      = e0 + n*(N_IN+2) + N_IN + 1;
      sb.push_back(e);
    end
    e.is_done = 1'b1;
    e.idx     = bi;
    e.data    = '0;
    e.at      = e0 + PASS_CYC;
    sb.push_back(e);
    last_class = bi;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (bus.out_valid || bus.done)) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: out_valid=%0b done=%0b at cycle %0d, none expected",
                 bus.out_valid, bus.done, cyc);
      end else begin
        e = sb.pop_front();
        check("pulse_kind_done", longint'(bus.done), longint'(e.is_done));
        check("pulse_cycle", longint'(cyc), longint'(e.at));
        if (e.is_done) begin
          check("class_idx", longint'(bus.class_idx), longint'(e.idx));
        end else begin
          check("out_idx", longint'(bus.out_idx), longint'(e.idx));
          check("out_data", longint'({48'h0, bus.out_data}), longint'({48'h0, e.data}));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      longint'(bus.busy), 0);
    check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
    check({tag, "_done"},      longint'(bus.done), 0);
    check({tag, "_x_addr"},    longint'(bus.x_addr), 0);
    check({tag, "_w_addr"},    longint'(bus.w_addr), 0);
    check({tag, "_b_addr"},    longint'(bus.b_addr), 0);
    check({tag, "_out_data"},  longint'({48'h0, bus.out_data}), 0);
    check({tag, "_out_idx"},   longint'(bus.out_idx), 0);
    check({tag, "_class_idx"}, longint'(bus.class_idx), 0);
  endtask

  task automatic start_pass(input bit hold, output int unsigned e0);
    @(negedge clk);
    check("idle_before_start", longint'(bus.busy), 0);
    e0 = cyc + 1;
    push_pass(e0);
    bus.start = 1'b1;
    @(negedge clk);
    check("busy_after_start", longint'(bus.busy), 1);
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic wait_drain(input int unsigned budget);
    int unsigned t = 0;
    while (sb.size() != 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout_pending", longint'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
    check("busy_after_pass", longint'(bus.busy), 0);
    check("done_one_cycle", longint'(bus.done), 0);
    check("class_idx_hold", longint'(bus.class_idx), longint'(last_class));
  endtask

  task automatic set_mem(input int xv, input int wv, input int bstep);
    for (int i = 0; i < N_IN; i++) xmem[i] = 16'(xv);
    for (int i = 0; i < N_IN*N_OUT; i++) wmem[i] = 16'(wv);
    for (int n = 0; n < N_OUT; n++) bmem[n] = 16'(n * bstep);
  endtask

  task automatic rand_mem(input bit narrow);
    for (int i = 0; i < N_IN; i++)
      xmem[i] = narrow ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
    for (int i = 0; i < N_IN*N_OUT; i++)
      wmem[i] = narrow ? 16'($urandom_range(0, 1023) - 512) : 16'($urandom);
    for (int n = 0; n < N_OUT; n++)
      bmem[n] = narrow ? 16'($urandom_range(0, 4095) - 2048) : 16'($urandom);
  endtask

  initial begin
    int unsigned e0;
    bus.start = 1'b0;
    set_mem(0, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Unity weights, tie everywhere; a second start mid-pass must be ignored.
    set_mem(16'h0100, 16'h0100, 0);
    start_pass(1'b0, e0);
    while (cyc < e0 + 49) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain(2*PASS_CYC);

    set_mem(0, 0, 16'h0100);
    start_pass(1'b0, e0);
    wait_drain(2*PASS_CYC);

    set_mem(16'h7FFF, 16'h7FFF, 0);
    start_pass(1'b0, e0);
    wait_drain(2*PASS_CYC);

    set_mem(16'h7FFF, 16'h8000, 0);
    start_pass(1'b0, e0);
    wait_drain(2*PASS_CYC);

    set_mem(16'hFFFF, 16'h0080, 0);
    start_pass(1'b0, e0);
    wait_drain(2*PASS_CYC);

    set_mem(0, 0, 0);
    xmem[0] = 16'hFFFF;
    wmem[0] = 16'h0001;
    start_pass(1'b0, e0);
    wait_drain(2*PASS_CYC);

    // Reset mid-pass: the remaining pulses of that pass must never appear.
    rand_mem(1'b1);
    start_pass(1'b0, e0);
    while (cyc < e0 + 59) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midpass_reset");
    rst = 1'b0;
    sb.delete();
    repeat (PASS_CYC + 20) @(negedge clk);

    for (int p = 0; p < 4; p++) begin
      rand_mem(p[0]);
      start_pass(1'b0, e0);
      wait_drain(2*PASS_CYC);
    end

    // start held high: second pass begins after one idle cycle.
    rand_mem(1'b1);
    start_pass(1'b1, e0);
    push_pass(e0 + PASS_CYC + 2);
    while (cyc < e0 + PASS_CYC + 2) @(negedge clk);
    bus.start = 1'b0;
    wait_drain(3*PASS_CYC);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
